// File: rtl/absval_rr_sched.sv
// Round-robin front end sharing one two's-complement absolute-value unit among
// 2**IDW requesters; 2-stage pipeline (operand reg, result reg) with ID tagging.
module absval_rr_sched #(
  parameter int width = 8,
  parameter int IDW   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(1<<IDW)-1:0]           req_valid,
  input  logic [(1<<IDW)*width-1:0]     req_data,
  output logic [(1<<IDW)-1:0]           req_ready,
  output logic                          rsp_valid,
  output logic [width-1:0]              rsp_data,
  output logic [IDW-1:0]                rsp_id,
  output logic                          rsp_ovf,
  input  logic                          rsp_ready
);
  localparam int NREQ = 1 << IDW;
  localparam logic [width-1:0] MOST_NEG = {1'b1, {(width-1){1'b0}}};

  logic [IDW-1:0]   ptr;
  logic             a_valid;
  logic [width-1:0] a_data;
  logic [IDW-1:0]   a_id;

  logic             b_load, a_adv, a_load, accept, found;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_id, idx;
  logic [width-1:0] abs_val;
  logic             ovf;

  assign b_load = ~rsp_valid | rsp_ready;
  assign a_adv  = a_valid & b_load;
  assign a_load = ~a_valid | b_load;

  // First valid requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IDW'(k);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gnt_id      = idx;
      end
    end
  end

  assign accept    = found & a_load & ~rst;
  assign req_ready = grant & {NREQ{a_load & ~rst}};

  // Most-negative wraps to itself under negation; flagged via ovf
  assign abs_val = a_data[width-1] ? (~a_data + width'(1)) : a_data;
  assign ovf     = (a_data == MOST_NEG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      a_valid <= 1'b0;
      a_data  <= '0;
      a_id    <= '0;
    end else begin
      if (accept) begin
        ptr     <= gnt_id + IDW'(1);
        a_valid <= 1'b1;
        a_data  <= req_data[gnt_id*width +: width];
        a_id    <= gnt_id;
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_ovf   <= 1'b0;
    end else if (b_load) begin
      rsp_valid <= a_valid;
      if (a_valid) begin
        rsp_data <= abs_val;
        rsp_id   <= a_id;
        rsp_ovf  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_absval_rr_sched.sv
// Directed bench for absval_rr_sched (width 8, four requesters) with
// hand-computed expected handshakes and results.
module tb_absval_rr_sched;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*W-1:0]    req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [W-1:0]         rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_ovf;
  logic                 rsp_ready;

  int n_cmp = 0;
  int n_err = 0;

  absval_rr_sched #(.width(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [W-1:0] d, input logic [IDW-1:0] id,
                         input logic ovf);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".data"},  32'(rsp_data),  32'(d));
    chk({tag, ".id"},    32'(rsp_id),    32'(id));
    chk({tag, ".ovf"},   32'(rsp_ovf),   32'(ovf));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Operands -1, -2, 3, -4 -> magnitudes 1..4
  task automatic load_rr_data();
    req_data[0*W +: W] = 8'hFF;
    req_data[1*W +: W] = 8'hFE;
    req_data[2*W +: W] = 8'h03;
    req_data[3*W +: W] = 8'hFC;
  endtask

  int acc;
  logic [IDW-1:0] eid;

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset state, req_ready gated even with requests pending
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'h0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst.rsp_data",  32'(rsp_data),  32'h0);
    chk("rst.rsp_id",    32'(rsp_id),    32'h0);
    chk("rst.rsp_ovf",   32'(rsp_ovf),   32'h0);

    // Single request: -10 -> 10
    do_reset();
    req_data[0*W +: W] = 8'hF6;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single.req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single.req_ready_off", 32'(req_ready), 32'h0);
    chk("single.early_valid", 32'(rsp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk_rsp("single", 8'h0A, 2'd0, 1'b0);
    tick();
    @(negedge clk);
    chk("single.drain", 32'(rsp_valid), 32'h0);

    // Round-robin with all four valid from reset
    do_reset();
    load_rr_data();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("rr.grant0", 32'(req_ready), 32'h1);
    chk("rr.fill0",  32'(rsp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("rr.grant1", 32'(req_ready), 32'h2);
    chk("rr.fill1",  32'(rsp_valid), 32'h0);
    tick();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      eid = IDW'(j % 4);
      chk_rsp($sformatf("rr.rsp%0d", j), W'(eid) + 8'd1, eid, 1'b0);
      tick();
    end

    // Pointer wrap: 3 alone, then 3 and 1 -> 1 before 3
    do_reset();
    req_data[3*W +: W] = 8'h05;
    req_valid = 4'b1000;
    @(negedge clk);
    chk("wrap.grant3", 32'(req_ready), 32'h8);
    tick();
    req_data[1*W +: W] = 8'h07;
    req_data[3*W +: W] = 8'hF7;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("wrap.grant1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("wrap.grant3b", 32'(req_ready), 32'h8);
    chk_rsp("wrap.r0", 8'h05, 2'd3, 1'b0);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk_rsp("wrap.r1", 8'h07, 2'd1, 1'b0);
    tick();
    @(negedge clk);
    chk_rsp("wrap.r2", 8'h09, 2'd3, 1'b0);

    // Most-negative and zero
    do_reset();
    req_data[0*W +: W] = 8'h80;
    req_valid = 4'b0001;
    tick();
    req_data[0*W +: W] = 8'h00;
    @(negedge clk);
    chk("edge.grant_zero", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk_rsp("edge.mostneg", 8'h80, 2'd0, 1'b1);
    tick();
    @(negedge clk);
    chk_rsp("edge.zero", 8'h00, 2'd0, 1'b0);

    // Back-pressure: 5 stalled cycles -> 2 accepts, B held
    do_reset();
    load_rr_data();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    acc = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != 0) acc++;
      if (j >= 2) begin
        chk($sformatf("bp.no_ready%0d", j), 32'(req_ready), 32'h0);
        chk_rsp($sformatf("bp.hold%0d", j), 8'h01, 2'd0, 1'b0);
      end
      tick();
    end
    chk("bp.accepts", 32'(acc), 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.resume_grant", 32'(req_ready), 32'h4);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge clk);
      eid = IDW'(j % 4);
      chk_rsp($sformatf("bp.rsp%0d", j), W'(eid) + 8'd1, eid, 1'b0);
      tick();
    end

    // Reset mid-flight with A and B full
    #1;
    rst = 1'b1;
    #1;
    chk("mid.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid.rsp_data",  32'(rsp_data),  32'h0);
    chk("mid.rsp_id",    32'(rsp_id),    32'h0);
    chk("mid.rsp_ovf",   32'(rsp_ovf),   32'h0);
    chk("mid.req_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid.prio0", 32'(req_ready), 32'h1);
    chk("mid.no_stale0", 32'(rsp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("mid.no_stale1", 32'(rsp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk_rsp("mid.first", 8'h01, 2'd0, 1'b0);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
